// File: rtl/retospect_cfg_pkg.sv
// Shared types and constants for the neurochip configuration loader.
package retospect_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERIFY,
    ST_NNRST,
    ST_DONE
  } cfg_state_t;

  localparam logic [7:0]  CRC8_POLY     = 8'h07;
  localparam int unsigned CLOCKBOX_BITS = 48;
  localparam int unsigned CELL_BITS     = 19;

  // Chain length for an X by Y cell array behind the clockbox.
  function automatic int unsigned chain_len(input int unsigned x, input int unsigned y);
    return CLOCKBOX_BITS + x * y * CELL_BITS;
  endfunction

endpackage

// File: rtl/retospect_cfg_loader_if.sv
// Byte stream from the host into the configuration loader (valid/ready).
interface retospect_cfg_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/retospect_crc8_serial.sv
// Bit-serial CRC-8 (init 0x00), one message bit per enabled cycle.
module retospect_crc8_serial
  import retospect_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  logic fb;
  assign fb = crc[7] ^ din;

  // CRC register: clear has priority over shifting in a new bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/retospect_cfg_loader.sv
// Configuration chain loader: serialises host bytes onto config_en/bs_in,
// optionally recirculates the chain to CRC-check it, then pulses reset_nn.
module retospect_cfg_loader
  import retospect_cfg_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = chain_len(5, 5),
  parameter int unsigned CW        = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  verify_en,
  retospect_cfg_loader_if.slave bus,
  output logic                  cfg_en,
  output logic                  cfg_bs,
  input  logic                  cfg_bs_ret,
  output logic                  nn_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  err_underrun,
  output logic                  err_crc
);

  localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] ALL_BITS = CW'(CHAIN_LEN);
  localparam logic [CW:0]   ALL_BITS_W = (CW+1)'(CHAIN_LEN);

  cfg_state_t    state, state_nxt;
  logic [7:0]    cur, nxt;
  logic [3:0]    cur_cnt;
  logic          nxt_full;
  logic [CW-1:0] bit_cnt;
  logic          verify_q;
  logic [7:0]    crc_load, crc_ret;

  logic          emit, underrun, need_more, ready, accept, cur_free, crc_clr;
  logic [CW:0]   pending;

  // A bit goes out whenever the shifting stage holds one.
  assign emit     = (state == ST_LOAD) && (cur_cnt != 4'd0);
  // Starved after the first bit but before the chain is full.
  assign underrun = (state == ST_LOAD) && (bit_cnt != '0) && (bit_cnt != ALL_BITS)
                    && (cur_cnt == 4'd0);
  // Bits already sent plus bits waiting in cur; no more bytes once that covers the chain.
  assign pending   = {1'b0, bit_cnt} + (CW+1)'(cur_cnt);
  assign need_more = pending < ALL_BITS_W;
  assign ready     = (state == ST_LOAD) && !nxt_full && need_more && !underrun;
  assign bus.in_ready = ready;
  assign accept    = bus.in_valid && ready;
  // cur is empty now or shifts out its last bit this cycle.
  assign cur_free  = (cur_cnt <= 4'd1);
  assign crc_clr   = (state == ST_IDLE) && start;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    state_nxt = state;
    cfg_en    = 1'b0;
    cfg_bs    = 1'b0;
    nn_reset  = 1'b0;
    done      = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        cfg_en = emit;
        cfg_bs = emit & cur[0];
        if (bit_cnt == ALL_BITS) begin
          state_nxt = verify_q ? ST_VERIFY : ST_NNRST;
        end else if (underrun) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_VERIFY: begin
        cfg_en = 1'b1;
        cfg_bs = cfg_bs_ret;
        if (bit_cnt == LAST_BIT) state_nxt = ST_NNRST;
      end
      ST_NNRST: begin
        nn_reset  = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Byte stages, bit counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur          <= '0;
      nxt          <= '0;
      cur_cnt      <= '0;
      nxt_full     <= 1'b0;
      bit_cnt      <= '0;
      verify_q     <= 1'b0;
      err_underrun <= 1'b0;
      err_crc      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            err_underrun <= 1'b0;
            err_crc      <= 1'b0;
            verify_q     <= verify_en;
            bit_cnt      <= '0;
            cur_cnt      <= '0;
            nxt_full     <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (emit) begin
            bit_cnt <= bit_cnt + CW'(1);
            cur     <= cur >> 1;
            cur_cnt <= cur_cnt - 4'd1;
            if (bit_cnt == LAST_BIT) begin
              // Chain complete: unused high bits of the final byte are dropped.
              cur_cnt  <= '0;
              nxt_full <= 1'b0;
            end else if ((cur_cnt == 4'd1) && nxt_full) begin
              cur      <= nxt;
              cur_cnt  <= 4'd8;
              nxt_full <= 1'b0;
            end
          end
          // Accept only happens with nxt empty, so it never collides with the move above;
          // a byte arriving as cur drains goes straight into cur to avoid a bubble.
          if (accept) begin
            if (cur_free) begin
              cur     <= bus.in_data;
              cur_cnt <= 4'd8;
            end else begin
              nxt      <= bus.in_data;
              nxt_full <= 1'b1;
            end
          end
          if (bit_cnt == ALL_BITS) bit_cnt <= '0;
          if (underrun) err_underrun <= 1'b1;
        end
        ST_VERIFY: begin
          bit_cnt <= bit_cnt + CW'(1);
        end
        ST_NNRST: begin
          if (verify_q && (crc_ret != crc_load)) err_crc <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  retospect_crc8_serial u_crc_load (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .en    (emit),
    .din   (cur[0]),
    .crc   (crc_load)
  );

  retospect_crc8_serial u_crc_ret (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .en    (state == ST_VERIFY),
    .din   (cfg_bs_ret),
    .crc   (crc_ret)
  );

endmodule

// File: tb/tb_retospect_cfg_loader.sv
// Scoreboard bench for retospect_cfg_loader with a chain shift-register model.
module tb_retospect_cfg_loader;
  import retospect_cfg_pkg::*;

  localparam int unsigned L      = 523;
  localparam int unsigned LS     = 5;
  localparam int unsigned NBYTES = (L + 7) / 8;

  typedef struct {
    bit is_done;
    int latency;
    bit e_crc;
    bit e_und;
    int nnr;
    int en;
    int ones;
    bit chk_chain;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0, verify_en = 1'b0;
  logic cfg_en, cfg_bs, cfg_bs_ret, nn_reset, busy, done, err_underrun, err_crc;
  logic start_s = 1'b0;
  logic cfg_en_s, cfg_bs_s, nn_reset_s, busy_s, done_s, err_underrun_s, err_crc_s;

  retospect_cfg_loader_if bus ();
  retospect_cfg_loader_if bus_s ();

  retospect_cfg_loader #(.CHAIN_LEN(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .verify_en(verify_en), .bus(bus.slave),
    .cfg_en(cfg_en), .cfg_bs(cfg_bs), .cfg_bs_ret(cfg_bs_ret), .nn_reset(nn_reset),
    .busy(busy), .done(done), .err_underrun(err_underrun), .err_crc(err_crc)
  );

  retospect_cfg_loader #(.CHAIN_LEN(LS)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .verify_en(1'b0), .bus(bus_s.slave),
    .cfg_en(cfg_en_s), .cfg_bs(cfg_bs_s), .cfg_bs_ret(1'b0), .nn_reset(nn_reset_s),
    .busy(busy_s), .done(done_s), .err_underrun(err_underrun_s), .err_crc(err_crc_s)
  );

  int checks = 0, errors = 0;
  int cyc = 0;
  exp_t exp_q[$];
  exp_t exp_s[$];
  logic [7:0] stim [NBYTES];

  // Chain model: config_en shifts bs_in into bit 0, bs_out is the top bit.
  logic [L-1:0] chain = '0;
  bit corrupt_arm = 1'b0;
  int en_cnt = 0;
  assign cfg_bs_ret = chain[L-1] ^ (corrupt_arm && (en_cnt == 600));
  always @(posedge clk) if (cfg_en) chain <= {chain[L-2:0], cfg_bs};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit chain_match();
    for (int i = 0; i < L; i++)
      if (chain[L-1-i] != stim[i/8][i%8]) return 1'b0;
    return 1'b1;
  endfunction

  // Main monitor: track activity since start, score each completion event.
  int first_acc = 0, nnr_cnt = 0;
  bit seen_acc = 1'b0, und_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (start && !busy) begin
      seen_acc = 1'b0; en_cnt = 0; nnr_cnt = 0;
    end else begin
      if (bus.in_valid && bus.in_ready && !seen_acc) begin
        seen_acc = 1'b1; first_acc = cyc;
      end
      if (cfg_en) en_cnt++;
      if (nn_reset) nnr_cnt++;
      if (done || (err_underrun && !und_prev)) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected completion: done=%0d underrun=%0d", done, err_underrun);
        end else begin
          e = exp_q.pop_front();
          check("completion kind (done)", int'(done), int'(e.is_done));
          if (e.is_done) check("accept-to-done latency", cyc - first_acc, e.latency);
          check("err_crc", int'(err_crc), int'(e.e_crc));
          check("err_underrun", int'(err_underrun), int'(e.e_und));
          check("nn_reset pulses", nnr_cnt, e.nnr);
          check("cfg_en cycles", en_cnt, e.en);
          if (e.chk_chain) check("chain contents", int'(chain_match()), 1);
        end
      end
    end
    und_prev = err_underrun;
  end

  // Small-chain monitor.
  int en_s = 0, ones_s = 0, nnr_s = 0, acc_s = 0;
  always @(negedge clk) begin
    exp_t e;
    if (start_s && !busy_s) begin
      en_s = 0; ones_s = 0; nnr_s = 0;
    end else begin
      if (bus_s.in_valid && bus_s.in_ready) acc_s = cyc;
      if (cfg_en_s) en_s++;
      if (cfg_en_s && cfg_bs_s) ones_s++;
      if (nn_reset_s) nnr_s++;
      if (done_s) begin
        if (exp_s.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected small-chain done");
        end else begin
          e = exp_s.pop_front();
          check("small latency", cyc - acc_s, e.latency);
          check("small cfg_en cycles", en_s, e.en);
          check("small ones shifted", ones_s, e.ones);
          check("small nn_reset pulses", nnr_s, e.nnr);
        end
      end
    end
  end

  task automatic do_start(input bit v);
    start = 1'b1; verify_en = v;
    @(posedge clk); #1;
    start = 1'b0; verify_en = 1'b0;
    check("busy,in_ready one cycle after start", int'({busy, bus.in_ready}), 3);
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    int t = 0;
    ok = 1'b0;
    bus.in_data = b; bus.in_valid = 1'b1;
    while (t < 40) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
      if (!busy) break;
      t++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Hold valid low for g cycles in which the loader is ready.
  task automatic gap(input int g);
    int n = 0, t = 0;
    bus.in_valid = 1'b0;
    while (n < g && t < 100 && busy) begin
      @(negedge clk);
      if (bus.in_ready) n++;
      t++;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int limit);
    int t = 0;
    while (busy && t < limit) begin @(negedge clk); t++; end
    check("returned to idle", int'(busy), 0);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic run_load(input bit v, input int gap_idx, input int gap_len, input int poke_idx);
    bit ok;
    do_start(v);
    for (int i = 0; i < NBYTES; i++) begin
      if (i == gap_idx) gap(gap_len);
      if (!busy) break;
      if (i == poke_idx) begin start = 1'b1; verify_en = 1'b1; end
      send_byte(stim[i], ok);
      start = 1'b0; verify_en = 1'b0;
      if (!ok) break;
    end
    wait_idle(1200);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int t;
    for (int i = 0; i < NBYTES; i++) stim[i] = 8'(i * 29 + 11);
    bus.in_data = '0; bus.in_valid = 1'b0;
    bus_s.in_data = '0; bus_s.in_valid = 1'b0;

    repeat (3) @(negedge clk);
    check("reset outputs", int'({bus.in_ready, cfg_en, cfg_bs, nn_reset, busy, done,
                                 err_underrun, err_crc}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full load with verify, back-to-back bytes.
    exp_q.push_back('{1, 2*L+3, 0, 0, 1, 2*L, 0, 1});
    run_load(1'b1, -1, 0, -1);

    // No verify; a start (with verify_en) mid-load must be ignored.
    exp_q.push_back('{1, L+3, 0, 0, 1, L, 0, 1});
    run_load(1'b0, -1, 0, 30);

    // Byte 10 arrives on the last ready cycle before cur drains: no underrun.
    exp_q.push_back('{1, L+3, 0, 0, 1, L, 0, 1});
    run_load(1'b0, 9, 7, -1);

    // Byte 10 withheld for 9 ready cycles: underrun after 9 bytes, no done.
    exp_q.push_back('{0, 0, 0, 1, 0, 72, 0, 0});
    run_load(1'b0, 9, 9, -1);
    repeat (20) @(negedge clk);
    check("idle after underrun", int'(busy), 0);
    check("underrun sticky", int'(err_underrun), 1);

    // One returned bit inverted during verify: CRC error flagged, flow completes.
    corrupt_arm = 1'b1;
    exp_q.push_back('{1, 2*L+3, 1, 0, 1, 2*L, 0, 0});
    run_load(1'b1, -1, 0, -1);
    corrupt_arm = 1'b0;

    // Asynchronous reset at bit 200 of LOAD.
    do_start(1'b1);
    for (int i = 0; i < 26; i++) send_byte(stim[i], ok);
    t = 0;
    while (en_cnt < 200 && t < 100) begin @(negedge clk); t++; end
    check("reached bit 200", en_cnt, 200);
    rst_n = 1'b0;
    #1;
    check("outputs on async reset", int'({bus.in_ready, cfg_en, cfg_bs, nn_reset, busy, done,
                                          err_underrun, err_crc}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle after reset release", int'(busy), 0);
    @(posedge clk); #1;

    // Short chain: one 0xFF byte, only 5 bits shifted.
    exp_s.push_back('{1, LS+3, 0, 0, 1, LS, LS, 0});
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    bus_s.in_data = 8'hFF; bus_s.in_valid = 1'b1;
    t = 0;
    while (t < 20) begin
      @(negedge clk);
      if (bus_s.in_ready) break;
      t++;
    end
    @(posedge clk); #1;
    bus_s.in_valid = 1'b0;
    t = 0;
    while (busy_s && t < 50) begin @(negedge clk); t++; end
    check("small returned to idle", int'(busy_s), 0);
    repeat (4) @(negedge clk);

    check("scoreboard drained", exp_q.size() + exp_s.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
